// File: rtl/bcd_xs3_codec.sv
// Multi-digit BCD <-> Excess-3 converter, one digit per clock, LSD first, valid/ready on both sides.
// Optional invalid-code detection is enabled by defining BCD_XS3_ERR_CHECK_EN.
module bcd_xs3_codec #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   din,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   dout,
  output logic [DIGITS-1:0]     err
);
  localparam int CW = $clog2(DIGITS+1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   din_q, din_d;
  logic                  mode_q, mode_d;
  logic [4*DIGITS-1:0]   dout_q, dout_d;
  logic [3:0]            cur, conv;
`ifdef BCD_XS3_ERR_CHECK_EN
  logic [DIGITS-1:0]     err_q, err_d;
  logic                  bad;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      din_q   <= '0;
      mode_q  <= 1'b0;
      dout_q  <= '0;
`ifdef BCD_XS3_ERR_CHECK_EN
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
`ifdef BCD_XS3_ERR_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
`ifdef BCD_XS3_ERR_CHECK_EN
    err_d   = err_q;
`endif
    cur = 4'd0;
    for (int i = 0; i < DIGITS; i++)
      if (cnt_q == CW'(i)) cur = din_q[4*i +: 4];
    // 4-bit wrap gives the plain modulo-16 result for out-of-range codes
    conv = mode_q ? (cur - 4'd3) : (cur + 4'd3);
`ifdef BCD_XS3_ERR_CHECK_EN
    bad  = mode_q ? ((cur < 4'd3) || (cur > 4'd12)) : (cur > 4'd9);
`endif

    case (state_q)
      IDLE: begin
        if (in_valid && en) begin
          din_d   = din;
          mode_d  = mode;
          dout_d  = '0;
`ifdef BCD_XS3_ERR_CHECK_EN
          err_d   = '0;
`endif
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        if (en) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CW'(i)) begin
`ifdef BCD_XS3_ERR_CHECK_EN
              dout_d[4*i +: 4] = bad ? 4'hF : conv;
              err_d[i]         = bad;
`else
              dout_d[4*i +: 4] = conv;
`endif
            end
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DIGITS-1)) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // rstn gating keeps in_ready low while reset is held, independent of en
  assign in_ready  = rstn && en && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign dout      = dout_q;
`ifdef BCD_XS3_ERR_CHECK_EN
  assign err       = err_q;
`else
  assign err       = '0;
`endif

endmodule

// File: tb/tb_bcd_xs3_codec.sv
// Self-checking bench for bcd_xs3_codec (DIGITS=4): directed table, corner sequences, random words.
module tb_bcd_xs3_codec;
  localparam int DIGITS = 4;

  logic                clk = 1'b0;
  logic                rstn, en, mode, in_valid, out_ready;
  logic                in_ready, out_valid;
  logic [4*DIGITS-1:0] din, dout;
  logic [DIGITS-1:0]   err;

  int nvec = 0;
  int nfail = 0;

  bcd_xs3_codec #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rstn(rstn), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .din(din), .out_valid(out_valid),
    .out_ready(out_ready), .dout(dout), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [15:0] d;
    logic [15:0] exp_dout;
    logic [3:0]  exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: digit-wise +/-3 modulo 16, invalid codes optionally flagged and forced to F.
  function automatic logic [19:0] model(input logic m, input logic [15:0] d);
    logic [15:0] o;
    logic [3:0]  e;
    o = '0;
    e = '0;
    for (int i = 0; i < DIGITS; i++) begin
      int v, r;
      bit invalid;
      v = int'(d[4*i +: 4]);
      r = m ? (v - 3 + 16) % 16 : (v + 3) % 16;
      invalid = m ? (v < 3 || v > 12) : (v > 9);
`ifdef BCD_XS3_ERR_CHECK_EN
      if (invalid) begin
        r = 15;
        e[i] = 1'b1;
      end
`else
      if (invalid) r = r;
`endif
      o[4*i +: 4] = 4'(r);
    end
    return {e, o};
  endfunction

  task automatic send(input logic m, input logic [15:0] d);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    mode = m; din = d; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; din = 16'($urandom); mode = 1'($urandom);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    if (cyc >= 100) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_hs", 32'(out_valid), 32'd0);
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[5];

  initial begin
    int cyc;
    logic [19:0] r;
    logic [15:0] held;

    vecs[0] = '{1'b0, 16'h1234, 16'h4567, 4'b0000};
    vecs[1] = '{1'b1, 16'h4567, 16'h1234, 4'b0000};
    vecs[2] = '{1'b1, 16'hC3C3, 16'h9090, 4'b0000};
`ifdef BCD_XS3_ERR_CHECK_EN
    vecs[3] = '{1'b0, 16'h9A05, 16'hCF38, 4'b0100};
`else
    vecs[3] = '{1'b0, 16'h9A05, 16'hCD38, 4'b0000};
`endif
    vecs[4] = '{1'b0, 16'h0999, 16'h3CCC, 4'b0000};

    rstn = 1'b0; en = 1'b1; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].m, vecs[i].d);
      wait_out(cyc);
      chk("latency", 32'(cyc), 32'd4);
      chk("tbl_dout", 32'(dout), 32'(vecs[i].exp_dout));
      chk("tbl_err", 32'(err), 32'(vecs[i].exp_err));
      take_out();
    end

    // back-pressure: DONE holds for 5 cycles, pulsed inputs ignored
    send(1'b0, 16'h1234);
    wait_out(cyc);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; din = 16'hFFFF;
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_dout", 32'(dout), 32'h4567);
      chk("bp_err", 32'(err), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    take_out();
    repeat (3) @(posedge clk);
    #1 chk("bp_no_queue", 32'(out_valid), 32'd0);

    // en stall of 3 cycles after digit 1
    send(1'b0, 16'h1234);
    repeat (2) @(posedge clk);
    #1 en = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_dout", 32'(dout), 32'h0067);
      chk("stall_out_valid", 32'(out_valid), 32'd0);
    end
    en = 1'b1;
    wait_out(cyc);
    chk("stall_latency", 32'(2 + 3 + cyc), 32'd7);
    chk("stall_final", 32'(dout), 32'h4567);
    take_out();

    // reset mid-CONV aborts the word
    send(1'b0, 16'h1234);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    chk("arst_dout", 32'(dout), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #3 rstn = 1'b1;
    @(posedge clk); #1;
    held = 16'h0999;
    send(1'b0, held);
    wait_out(cyc);
    chk("post_rst_latency", 32'(cyc), 32'd4);
    chk("post_rst_dout", 32'(dout), 32'h3CCC);
    take_out();

    // random words against the reference model
    for (int i = 0; i < 40; i++) begin
      logic m;
      logic [15:0] d;
      m = 1'($urandom);
      d = 16'($urandom);
      r = model(m, d);
      send(m, d);
      wait_out(cyc);
      chk("rnd_latency", 32'(cyc), 32'd4);
      chk("rnd_dout", 32'(dout), 32'(r[15:0]));
      chk("rnd_err", 32'(err), 32'(r[19:16]));
      take_out();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
